// File: rtl/imem_sync.sv
// imem_sync: synchronous-read instruction memory with a boot-time load port.
// The fetch port is byte addressed. Each response appears one cycle after its request.
// A stall holds the response registers.
// The BOOT/RUN mode FSM gates both ports: loads are taken only in BOOT, fetches only in RUN.
module imem_sync #(
   parameter int unsigned       DATA_W       = 32,
   parameter int unsigned       DEPTH        = 512,
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR    = 32'h0000_0013,
   parameter bit                START_IN_RUN = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_req,
   input  logic [ADDR_W-1:0]          fetch_addr,
   input  logic                       fetch_stall,
   output logic                       fetch_valid,
   output logic [DATA_W-1:0]          fetch_instr,
   output logic                       fetch_fault,
   input  logic                       load_we,
   input  logic [$clog2(DEPTH)-1:0]   load_addr,
   input  logic [DATA_W-1:0]          load_data,
   input  logic                       load_done,
   input  logic                       boot_req,
   output logic [$clog2(DEPTH):0]     load_count,
   output logic                       load_err,
   output logic                       mode_run
);

   localparam int unsigned LA_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W = LA_W + 1;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam state_e RESET_STATE = START_IN_RUN ? ST_RUN : ST_BOOT;

   // Instruction store; deliberately not cleared by reset so that preloaded images survive
   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q;
   logic              valid_q;
   logic [DATA_W-1:0] instr_q;
   logic              fault_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              err_q;

   logic [ADDR_W-3:0] fetch_word_s;
   logic [LA_W-1:0]   fetch_idx_s;
   logic              fetch_ok_s;
   logic [DATA_W-1:0] instr_d;
   logic              fault_d;
   logic              load_wr_s;

   // Decode the fetch address and pick the response word. Bad addresses yield the NOP.
   always_comb begin
      fetch_word_s = fetch_addr[ADDR_W-1:2];
      fetch_idx_s  = fetch_addr[LA_W+1:2];
      fetch_ok_s   = (fetch_addr[1:0] == 2'b00) &&
                     ({2'b00, fetch_word_s} < ADDR_W'(DEPTH));
      if (fetch_ok_s) begin
         instr_d = mem_q[fetch_idx_s];
         fault_d = 1'b0;
      end else begin
         instr_d = NOP_INSTR;
         fault_d = 1'b1;
      end
   end

   // A load write lands only in BOOT and only for an index inside the array
   always_comb begin
      load_wr_s = (state_q == ST_BOOT) && load_we &&
                  (CNT_W'(load_addr) < CNT_W'(DEPTH));
   end

   // Memory write port (no reset: contents persist across reset)
   always_ff @(posedge clk) begin
      if (load_wr_s) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Mode FSM with the registered fetch response, load counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_STATE;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         fault_q <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               valid_q <= 1'b0;
               if (load_wr_s && (cnt_q < CNT_W'(DEPTH))) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               if (load_done) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (load_we) begin
                  err_q <= 1'b1;
               end
               if (boot_req) begin
                  state_q <= ST_BOOT;
                  cnt_q   <= '0;
                  valid_q <= 1'b0;
               end else if (!fetch_stall) begin
                  valid_q <= fetch_req;
                  if (fetch_req) begin
                     instr_q <= instr_d;
                     fault_q <= fault_d;
                  end
               end
            end
            default: begin
               state_q <= RESET_STATE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign fetch_valid = valid_q;
   assign fetch_instr = instr_q;
   assign fetch_fault = fault_q;
   assign load_count  = cnt_q;
   assign load_err    = err_q;
   assign mode_run    = (state_q == ST_RUN);

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the RISC-Duo cores.
- Supports a configurable depth and a byte-addressed fetch port with one-cycle latency and a stall/hold handshake.
- Provides a boot-time program-load write port and fault flagging for misaligned or out-of-range fetches.
- Sits between the fetch stage (PC side) and the boot loader; replaces the combinational word-addressed instruction store in pipelined builds.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 512, number of instruction words; any value ≥ 2, not required to be a power of 2.
- ADDR_W, 32, fetch byte-address width.
- NOP_INSTR, 32'h0000_0013, value driven on fetch_instr at reset and on faults (addi x0,x0,0).
- START_IN_RUN, 0, 1 = leave reset directly in RUN (memory preloaded by simulation initialisation).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- fetch_req, input, 1, fetch request this cycle.
- fetch_addr, input, ADDR_W, fetch byte address.
- fetch_stall, input, 1, downstream stall: hold the response registers.
- fetch_valid, output, 1, response valid.
- fetch_instr, output, DATA_W, fetched instruction.
- fetch_fault, output, 1, the response is a misaligned or out-of-range fetch.
- load_we, input, 1, program-load write strobe.
- load_addr, input, $clog2(DEPTH), word index for the load write.
- load_data, input, DATA_W, word to write.
- load_done, input, 1, pulse: loading finished, enter RUN.
- boot_req, input, 1, pulse: return to BOOT, for reprogramming.
- load_count, output, $clog2(DEPTH)+1, number of accepted load writes since the last entry to BOOT.
- load_err, output, 1, sticky flag: a load write arrived in RUN.
- mode_run, output, 1, 1 when the FSM is in RUN.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - FSM = RUN if START_IN_RUN else BOOT.
  - fetch_valid=0, fetch_instr=NOP_INSTR, fetch_fault=0, load_count=0, load_err=0.
  - Memory array is not cleared.
- FSM, states BOOT and RUN:
  - BOOT→RUN on load_done; mode_run=1 from the next cycle.
  - RUN→BOOT on boot_req; load_count resets to 0 and fetch_valid clears on the same edge.
  - boot_req in BOOT and load_done in RUN are no-ops.
  - Both pulses high together: the transition out of the current state applies; the other pulse is ignored.
- Load port:
  - In BOOT, load_we writes mem[load_addr]=load_data on the edge, and load_count increments.
  - load_count saturates at DEPTH.
  - load_addr ≥ DEPTH is dropped, with no count increment.
  - In RUN, load_we is ignored and load_err is set; it clears only on reset.
- Fetch, RUN only; fetch_req in BOOT is ignored and fetch_valid stays 0.
  - Latency is 1 cycle: a request accepted at edge N shows its response after edge N.
  - Accepted when fetch_req=1 and fetch_stall=0.
  - Word index = fetch_addr[ADDR_W-1:2].
  - fetch_addr[1:0]≠0 → fetch_fault=1, fetch_instr=NOP_INSTR.
  - Word index ≥ DEPTH (including upper address bits set) → fetch_fault=1, fetch_instr=NOP_INSTR.
  - Otherwise fetch_instr=mem[index], fetch_fault=0.
  - fetch_valid=1 after an accepted request; fetch_valid=0 after a cycle with fetch_req=0 and no stall.
- Stall:
  - While fetch_stall=1, fetch_valid, fetch_instr and fetch_fault hold their values and fetch_req is not accepted.
  - The core must re-present the request after the stall.
- Writes never occur in RUN, so read/write collision is impossible. In BOOT, reads are disabled.
- No combinational path from any input to any output.

Test Plan:
- Reset, then load 0x00500093 at word 0 and 0x00A00113 at word 1, load_done → load_count=2, mode_run=1 next cycle. Fetch 0x0 then 0x4 → fetch_instr=0x00500093, then 0x00A00113, each one cycle after its request, fetch_fault=0.
- RUN, fetch_addr=0x6 → fetch_fault=1, fetch_instr=0x00000013. fetch_addr=4*DEPTH (0x800) → fetch_fault=1, NOP.
- Response 0x00A00113 valid, then fetch_stall=1 for 3 cycles while fetch_addr changes → outputs hold 0x00A00113, valid=1. Stall release with addr 0x0 → 0x00500093 next cycle.
- load_we in RUN → no memory change (re-fetch returns the old word), load_err=1 and stays set.
- boot_req and load_done asserted together in RUN → BOOT, fetch_valid=0, load_count=0. A fetch_req in BOOT yields fetch_valid=0.
- Assert rst_n=0 mid-fetch, asynchronously between edges → outputs reach reset values immediately, without waiting for a clock edge.
